// File: rtl/spi_multichannel_slave.sv
// SPI mode-0 slave: sample snapshot readout, coefficient bank read/write,
// and a status byte. Runs on SCLK. Frame state clears while cs_n is high.
module spi_multichannel_slave #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int NUM_COEFFS = 10,
  parameter int COEFF_W    = 32
) (
  input  logic                           SCLK,
  input  logic                           reset_n,
  input  logic                           cs_n,
  input  logic                           mosi,
  output logic                           miso,
  output logic                           miso_oe,
  input  logic [CHANNELS*SAMPLE_W-1:0]   sample_in,
  input  logic                           sample_req,
  output logic                           sample_ack,
  output logic [NUM_COEFFS*COEFF_W-1:0]  coeff_out,
  output logic                           coeff_wr_tgl,
  output logic [7:0]                     coeff_wr_idx
);
  localparam int SMP_W = CHANNELS * SAMPLE_W;
  localparam int RXW   = (COEFF_W > 8) ? COEFF_W : 8;
  localparam int TXW0  = (SMP_W > COEFF_W) ? SMP_W : COEFF_W;
  localparam int TXW   = (TXW0 > 8) ? TXW0 : 8;
  localparam int MAXW  = (TXW > RXW) ? TXW : RXW;
  localparam int CW    = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {S_CMD, S_IDX, S_TX, S_RX, S_DONE} state_e;

  state_e                               state_q;
  logic [CW-1:0]                        cnt_q;
  logic [TXW-1:0]                       shift_tx_q;
  logic [RXW-2:0]                       shift_rx_q;
  logic                                 miso_q;
  logic [7:0]                           cmd_q, idx_q;
  logic                                 req_meta_q, req_s_q;
  logic [SMP_W-1:0]                     hold_q;
  logic                                 fresh_q, bad_idx_q, bad_cmd_q;
  logic [NUM_COEFFS-1:0][COEFF_W-1:0]   coeff_q;
  logic                                 tgl_q;
  logic [7:0]                           widx_q;

  // Frame state is held in reset by either global reset or a deselected chip.
  logic frame_rst_n;
  assign frame_rst_n = reset_n & ~cs_n;

  logic [RXW-1:0]     rx_next;
  logic [7:0]         byte_in, status_w;
  logic               last8, cmd_done, idx_done, snap, cmd_bad;
  logic               idx_in_ok, wr_ok, commit, rd_bad, stat_last, tx_last;
  logic [CW-1:0]      tx_len_m1;
  logic [COEFF_W-1:0] rd_coeff;
  logic               req_rise;

  assign rx_next   = {shift_rx_q, mosi};
  assign byte_in   = rx_next[7:0];
  assign status_w  = {5'b0, fresh_q, bad_idx_q, bad_cmd_q};
  assign last8     = (cnt_q == CW'(7));
  assign cmd_done  = (state_q == S_CMD) && last8;
  assign idx_done  = (state_q == S_IDX) && last8;
  assign snap      = cmd_done && (byte_in == 8'h01);
  assign cmd_bad   = cmd_done && !(byte_in inside {8'h01, 8'h02, 8'h03, 8'h04});
  assign idx_in_ok = ({24'd0, byte_in} < 32'(NUM_COEFFS));
  assign wr_ok     = ({24'd0, idx_q} < 32'(NUM_COEFFS));
  assign commit    = (state_q == S_RX) && (cnt_q == CW'(COEFF_W - 1));
  assign rd_bad    = idx_done && (cmd_q == 8'h03) && !idx_in_ok;
  assign stat_last = (state_q == S_TX) && (cmd_q == 8'h04) && last8;
  assign tx_last   = (state_q == S_TX) && (cnt_q == tx_len_m1);
  assign req_rise  = req_meta_q & ~req_s_q;

  // Number of bits shifted out depends on which read command owns the frame.
  always_comb begin
    tx_len_m1 = CW'(7);
    case (cmd_q)
      8'h01:   tx_len_m1 = CW'(SMP_W - 1);
      8'h03:   tx_len_m1 = CW'(COEFF_W - 1);
      default: tx_len_m1 = CW'(7);
    endcase
  end

  // Coefficient read mux addressed by the index byte as it completes.
  always_comb begin
    rd_coeff = '0;
    for (int i = 0; i < NUM_COEFFS; i++)
      if (byte_in == 8'(i)) rd_coeff = coeff_q[i];
  end

  // Frame FSM: CMD -> IDX -> TX/RX -> DONE, cleared whenever cs_n is high.
  always_ff @(posedge SCLK or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q    <= S_CMD;
      cnt_q      <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
    end else begin
      shift_rx_q <= rx_next[RXW-2:0];
      cnt_q      <= cnt_q + CW'(1);
      case (state_q)
        S_CMD: if (last8) begin
          cnt_q <= '0;
          case (byte_in)
            8'h01: begin
              shift_tx_q <= TXW'(hold_q) << (TXW - SMP_W);
              state_q    <= S_TX;
            end
            8'h02, 8'h03: state_q <= S_IDX;
            8'h04: begin
              shift_tx_q <= TXW'(status_w) << (TXW - 8);
              state_q    <= S_TX;
            end
            default: state_q <= S_DONE;
          endcase
        end
        S_IDX: if (last8) begin
          cnt_q <= '0;
          if (cmd_q == 8'h02) state_q <= S_RX;
          else begin
            shift_tx_q <= idx_in_ok ? (TXW'(rd_coeff) << (TXW - COEFF_W)) : '0;
            state_q    <= S_TX;
          end
        end
        S_RX: if (commit) state_q <= S_DONE;
        S_TX: begin
          shift_tx_q <= shift_tx_q << 1;
          if (tx_last) state_q <= S_DONE;
        end
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // miso launches on the falling edge so the host can sample it on the rising edge.
  always_ff @(negedge SCLK or negedge frame_rst_n) begin
    if (!frame_rst_n) miso_q <= 1'b0;
    else              miso_q <= (state_q == S_TX) & shift_tx_q[TXW-1];
  end

  // Persistent state: handshake sync, sample hold, flags, coefficient bank.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      hold_q     <= '0;
      fresh_q    <= 1'b0;
      bad_idx_q  <= 1'b0;
      bad_cmd_q  <= 1'b0;
      coeff_q    <= '0;
      tgl_q      <= 1'b0;
      widx_q     <= '0;
      cmd_q      <= '0;
      idx_q      <= '0;
    end else begin
      req_meta_q <= sample_req;
      req_s_q    <= req_meta_q;
      if (req_rise) hold_q <= sample_in;
      // A capture on the snapshot edge wins: new data is unread.
      if (req_rise)  fresh_q <= 1'b1;
      else if (snap) fresh_q <= 1'b0;
      if (cmd_bad)        bad_cmd_q <= 1'b1;
      else if (stat_last) bad_cmd_q <= 1'b0;
      if (rd_bad || (commit && !wr_ok)) bad_idx_q <= 1'b1;
      else if (stat_last)               bad_idx_q <= 1'b0;
      if (cmd_done) cmd_q <= byte_in;
      if (idx_done) idx_q <= byte_in;
      if (commit && wr_ok) begin
        for (int i = 0; i < NUM_COEFFS; i++)
          if (idx_q == 8'(i)) coeff_q[i] <= rx_next[COEFF_W-1:0];
        widx_q <= idx_q;
        tgl_q  <= ~tgl_q;
      end
    end
  end

  assign miso         = miso_q;
  assign miso_oe      = ~cs_n;
  assign sample_ack   = req_s_q;
  assign coeff_out    = coeff_q;
  assign coeff_wr_tgl = tgl_q;
  assign coeff_wr_idx = widx_q;
endmodule
